// File: rtl/ucie_sb_pkg.sv
// Shared types and default parameters for the UCIe sideband transmit path.
package ucie_sb_pkg;

  typedef enum logic [1:0] {
    SB_TX_IDLE  = 2'd0,
    SB_TX_SHIFT = 2'd1,
    SB_TX_GAP   = 2'd2
  } sb_tx_state_e;

  localparam int SB_PKT_W_DEF      = 64;
  localparam int SB_MIN_GAP_UI_DEF = 32;
  localparam int SB_FIFO_DEPTH_DEF = 4;

endpackage

// File: rtl/ucie_sb_sync_fifo.sv
// Single-clock packet buffer with a registered occupancy count.
// Read data is presented combinationally from the head entry whenever the buffer is not empty.
module ucie_sb_sync_fifo
  import ucie_sb_pkg::*;
#(
  parameter int WIDTH = SB_PKT_W_DEF,
  parameter int DEPTH = SB_FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // A full buffer refuses writes even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + LVL_W'(1);
        2'b01:   count_q <= count_q - LVL_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_q];
  assign full    = (count_q == LVL_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;

endmodule

// File: rtl/ucie_sb_tx_serializer.sv
// UCIe sideband transmitter: buffers parallel packets and shifts them out one bit per UI,
// gating the forwarded clock and enforcing a minimum idle gap between packets.
module ucie_sb_tx_serializer
  import ucie_sb_pkg::*;
#(
  parameter int PKT_W      = SB_PKT_W_DEF,
  parameter int MIN_GAP_UI = SB_MIN_GAP_UI_DEF,
  parameter int FIFO_DEPTH = SB_FIFO_DEPTH_DEF,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [PKT_W-1:0]                in_data,
  input  logic                            tx_hold,
  output logic                            sbtx_clk_en,
  output logic                            sbtx_data,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic [15:0]                     pkt_sent_cnt
);

  // state | meaning
  // IDLE  | nothing in flight; start when a packet is buffered and not held
  // SHIFT | one packet bit per UI with the forwarded clock enabled
  // GAP   | forced idle UI after a packet; may chain straight into the next

  localparam logic [1:0] ST_IDLE  = SB_TX_IDLE;
  localparam logic [1:0] ST_SHIFT = SB_TX_SHIFT;
  localparam logic [1:0] ST_GAP   = SB_TX_GAP;

  localparam int BIT_W = $clog2(PKT_W);
  localparam int GAP_W = $clog2(MIN_GAP_UI + 1);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PKT_W - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP_UI);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [PKT_W-1:0] shift_q;
  logic [PKT_W-1:0] shift_nxt;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             cur_bit;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PKT_W-1:0] fifo_rd_data;

  logic             can_start;
  logic             gap_done;
  logic             last_bit;

  ucie_sb_sync_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (in_valid),
    .pop     (fifo_pop),
    .wr_data (in_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;

  // tx_hold only matters at packet-start decisions, so a packet in flight always completes.
  assign can_start = !fifo_empty && !tx_hold;
  assign gap_done  = (state_q == ST_GAP) && (gap_cnt_q == GAP_ONE);
  assign fifo_pop  = can_start && ((state_q == ST_IDLE) || gap_done);
  assign last_bit  = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_BIT);

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign cur_bit   = shift_q[PKT_W-1];
      assign shift_nxt = {shift_q[PKT_W-2:0], 1'b0};
    end else begin : g_lsb_first
      assign cur_bit   = shift_q[0];
      assign shift_nxt = {1'b0, shift_q[PKT_W-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_pop) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          state_d = fifo_pop ? ST_SHIFT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (fifo_pop) begin
      shift_q   <= fifo_rd_data;
      bit_cnt_q <= '0;
    end else if (state_q == ST_SHIFT) begin
      shift_q   <= shift_nxt;
      bit_cnt_q <= last_bit ? '0 : bit_cnt_q + BIT_W'(1);
    end
  end

  // Loading MIN_GAP_UI on the last-bit edge and chaining on count 1 yields exactly MIN_GAP_UI idle UI.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt_q <= '0;
    end else if (last_bit) begin
      gap_cnt_q <= GAP_LOAD;
    end else if ((state_q == ST_GAP) && (gap_cnt_q != '0)) begin
      gap_cnt_q <= gap_cnt_q - GAP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sbtx_clk_en <= 1'b0;
      sbtx_data   <= 1'b0;
    end else begin
      sbtx_clk_en <= (state_q == ST_SHIFT);
      sbtx_data   <= (state_q == ST_SHIFT) && cur_bit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_sent_cnt <= '0;
    end else if (last_bit) begin
      pkt_sent_cnt <= pkt_sent_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ucie_sb_tx_serializer.sv
// Bench for ucie_sb_tx_serializer: a default instance checked every cycle against a
// schedule-level model, plus a small-parameter instance checked against hand-built bit streams.
module tb_ucie_sb_tx_serializer;

  localparam int PW_A  = 64;
  localparam int GAP_A = 32;
  localparam int DEP_A = 4;
  localparam int PW_B  = 32;
  localparam int GAP_B = 1;
  localparam int DEP_B = 2;
  localparam int NLOG  = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_a, a_in_valid, a_in_ready, a_tx_hold, a_clk_en, a_data, a_busy;
  logic [PW_A-1:0] a_in_data;
  logic [2:0]      a_level;
  logic [15:0]     a_cnt;

  logic            reset_b, b_in_valid, b_in_ready, b_tx_hold, b_clk_en, b_data, b_busy;
  logic [PW_B-1:0] b_in_data;
  logic [1:0]      b_level;
  logic [15:0]     b_cnt;

  ucie_sb_tx_serializer #(
    .PKT_W (PW_A), .MIN_GAP_UI (GAP_A), .FIFO_DEPTH (DEP_A), .MSB_FIRST (1'b0)
  ) dut_a (
    .clk (clk), .reset (reset_a), .in_valid (a_in_valid), .in_ready (a_in_ready),
    .in_data (a_in_data), .tx_hold (a_tx_hold), .sbtx_clk_en (a_clk_en),
    .sbtx_data (a_data), .busy (a_busy), .fifo_level (a_level), .pkt_sent_cnt (a_cnt)
  );

  ucie_sb_tx_serializer #(
    .PKT_W (PW_B), .MIN_GAP_UI (GAP_B), .FIFO_DEPTH (DEP_B), .MSB_FIRST (1'b1)
  ) dut_b (
    .clk (clk), .reset (reset_b), .in_valid (b_in_valid), .in_ready (b_in_ready),
    .in_data (b_in_data), .tx_hold (b_tx_hold), .sbtx_clk_en (b_clk_en),
    .sbtx_data (b_data), .busy (b_busy), .fifo_level (b_level), .pkt_sent_cnt (b_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Model: a packet may start at edge k when buffered, not held, and k >= m_next_ok.
  int              cyc = 0;
  int              m_level = 0;
  logic [PW_A-1:0] m_q[$];
  logic [PW_A-1:0] m_cur = '0;
  int              m_start = -1;
  int              m_next_ok = 0;
  int              m_sent = 0;

  bit a_en_log  [NLOG];
  bit a_dat_log [NLOG];
  bit b_en_log  [NLOG];
  bit b_dat_log [NLOG];

  task automatic model_reset();
    m_q.delete();
    m_level   = 0;
    m_start   = -1;
    m_next_ok = 0;
    m_sent    = 0;
  endtask

  task automatic tick();
    bit   acc, st, exp_en, exp_dat, exp_busy;
    int   k;
    k   = cyc + 1;
    acc = !reset_a && a_in_valid && (m_level < DEP_A);
    st  = !reset_a && (m_level > 0) && !a_tx_hold && (k >= m_next_ok);
    @(posedge clk);
    cyc = k;
    if (reset_a) begin
      model_reset();
    end else begin
      if (st) begin
        m_cur     = m_q.pop_front();
        m_start   = k;
        m_next_ok = k + PW_A + GAP_A;
      end
      if (acc) m_q.push_back(a_in_data);
      m_level = m_level + int'(acc) - int'(st);
      if (m_start >= 0 && k == m_start + PW_A) m_sent = (m_sent + 1) % 65536;
    end
    #1;
    if (cyc < NLOG) begin
      a_en_log[cyc]  = a_clk_en;
      a_dat_log[cyc] = a_data;
      b_en_log[cyc]  = b_clk_en;
      b_dat_log[cyc] = b_data;
    end
    exp_en  = (m_start >= 0) && (cyc > m_start) && (cyc <= m_start + PW_A);
    exp_dat = 1'b0;
    if (exp_en) exp_dat = m_cur[cyc - m_start - 1];
    exp_busy = (m_level > 0) || ((m_start >= 0) && (cyc < m_start + PW_A + GAP_A));
    chk("a_clk_en", a_clk_en, exp_en);
    chk("a_data", a_data, exp_dat);
    chk("a_level", a_level, m_level);
    chk("a_in_ready", a_in_ready, m_level < DEP_A);
    chk("a_busy", a_busy, exp_busy);
    chk("a_pkt_cnt", a_cnt, m_sent);
  endtask

  function automatic int count_en(int lo, int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) begin
      if (i >= 0 && i < NLOG && a_en_log[i]) c++;
    end
    return c;
  endfunction

  function automatic int first_rise(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      if (i >= 1 && i < NLOG && a_en_log[i] && !a_en_log[i-1]) return i;
    end
    return -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int              t0, t_push, r_rel, f, cnt0;
    int              s[4];
    logic [PW_A-1:0] pay, got;
    logic [31:0]     pb;
    logic [127:0]    oe, ee, od, ed;

    reset_a = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_tx_hold = 1'b0;
    reset_b = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_tx_hold = 1'b0;

    // reset and idle
    repeat (5) tick();
    chk("rst_clk_en", a_clk_en, 0);
    chk("rst_data", a_data, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_level", a_level, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_b_in_ready", b_in_ready, 1);
    reset_a = 1'b0;
    reset_b = 1'b0;
    t0 = cyc;
    repeat (20) tick();
    chk("idle_no_pulse", count_en(t0 + 1, cyc), 0);

    // single packet, LSB first
    pay = 64'hA5A5_0000_FFFF_1234;
    a_in_valid = 1'b1; a_in_data = pay;
    tick();
    t_push = cyc;
    a_in_valid = 1'b0;
    repeat (110) tick();
    chk("single_first_en", first_rise(t_push + 1, cyc), t_push + 2);
    chk("single_en_len", count_en(t_push + 1, cyc), 64);
    got = '0;
    for (int i = 0; i < PW_A; i++) got[i] = a_dat_log[t_push + 2 + i];
    chk("single_payload", got, pay);
    chk("single_cnt", a_cnt, 1);

    // back-to-back with a full buffer
    cnt0 = a_cnt;
    a_tx_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1; a_in_data = {$urandom, $urandom};
      tick();
    end
    a_in_valid = 1'b0;
    chk("b2b_in_ready_full", a_in_ready, 0);
    chk("b2b_level_full", a_level, 4);
    a_tx_hold = 1'b0;
    r_rel = cyc;
    repeat (4 * 96 + 40) tick();
    s[0] = first_rise(r_rel + 1, cyc);
    for (int i = 1; i < 4; i++) s[i] = first_rise(s[i-1] + 1, cyc);
    chk("b2b_first_start", s[0], r_rel + 2);
    for (int i = 0; i < 4; i++) chk("b2b_en_len", count_en(s[i], s[i] + PW_A - 1), 64);
    for (int i = 1; i < 4; i++) begin
      chk("b2b_period", s[i] - s[i-1], 96);
      chk("b2b_gap_low", count_en(s[i-1] + PW_A, s[i] - 1), 0);
    end
    chk("b2b_cnt", a_cnt, (cnt0 + 4) % 65536);

    // tx_hold asserted mid-packet
    a_in_valid = 1'b1; a_in_data = {$urandom, $urandom};
    tick();
    t_push = cyc;
    a_in_data = {$urandom, $urandom};
    tick();
    a_in_valid = 1'b0;
    repeat (30) tick();
    a_tx_hold = 1'b1;
    chk("hold_mid_pkt", a_clk_en, 1);
    repeat (200) tick();
    chk("hold_pkt1_only", count_en(t_push + 1, cyc), 64);
    chk("hold_level", a_level, 1);
    a_tx_hold = 1'b0;
    r_rel = cyc;
    repeat (150) tick();
    f = first_rise(t_push + 66, cyc);
    chk("hold_resume", f, r_rel + 2);
    chk("hold_gap_min", (f - (t_push + 66)) >= 32, 1);
    chk("hold_pkt2_len", count_en(f, cyc), 64);

    // asynchronous reset at bit 20 of a packet with two more queued
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1; a_in_data = {$urandom, $urandom};
      tick();
    end
    a_in_valid = 1'b0;
    repeat (20) tick();
    chk("rstmid_active", a_clk_en, 1);
    chk("rstmid_queued", a_level, 2);
    #3;
    reset_a = 1'b1;
    #1;
    chk("rstmid_clk_en", a_clk_en, 0);
    chk("rstmid_data", a_data, 0);
    chk("rstmid_level", a_level, 0);
    chk("rstmid_cnt", a_cnt, 0);
    chk("rstmid_busy", a_busy, 0);
    model_reset();
    repeat (3) tick();
    reset_a = 1'b0;
    t0 = cyc;
    repeat (200) tick();
    chk("rstmid_no_residue", count_en(t0 + 1, cyc), 0);

    // randomized traffic and hold
    repeat (3000) begin
      a_in_valid = ($urandom_range(0, 99) < 35);
      a_in_data  = {$urandom, $urandom};
      if ($urandom_range(0, 99) < 4) a_tx_hold = ~a_tx_hold;
      tick();
    end
    a_in_valid = 1'b0;
    a_tx_hold  = 1'b0;
    repeat (500) tick();
    chk("rand_drained", a_level, 0);
    chk("rand_idle", a_busy, 0);

    // small configuration, MSB first, one idle UI
    pb = 32'h8000_0001;
    b_in_valid = 1'b1; b_in_data = pb;
    tick();
    t_push = cyc;
    tick();
    b_in_valid = 1'b0;
    repeat (100) tick();
    oe = '0; ee = '0; od = '0; ed = '0;
    for (int i = 0; i < 2 * PW_B + GAP_B; i++) begin
      oe[i] = b_en_log[t_push + 2 + i];
      od[i] = b_dat_log[t_push + 2 + i];
      ee[i] = (i != PW_B);
      if (i < PW_B)       ed[i] = pb[PW_B - 1 - i];
      else if (i > PW_B)  ed[i] = pb[PW_B - 1 - (i - PW_B - GAP_B)];
    end
    chk("swp_pre_en", b_en_log[t_push + 1], 0);
    chk("swp_first_bit", b_dat_log[t_push + 2], 1);
    chk("swp_en_pattern", oe, ee);
    chk("swp_data_pattern", od, ed);
    chk("swp_post_en", b_en_log[t_push + 2 + 2 * PW_B + GAP_B], 0);
    chk("swp_cnt", b_cnt, 2);
    chk("swp_level", b_level, 0);
    chk("swp_in_ready", b_in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
